// File: rtl/keypad_matrix_emulator.sv
// Emulates the row side of a 2x2 keypad matrix and plays back scripted presses.
// Optional contact bounce is built when the KEYEMU_BOUNCE_EN macro is defined.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   cmd_valid_i  command present
//   cmd_ready_o  command can be accepted (registered, high only in IDLE)
//   cmd_key_i    key id {row,col}
//   cmd_hold_i   press duration in cycles (0 behaves as 1)
//   col_in_i     asynchronous active-high column drive from the scanner
//   row_out_o    registered active-high row sense to the scanner
//   busy_o       high during PRESS and GAP
//   key_down_o   one-hot clean key state
module keypad_matrix_emulator #(
  parameter int HOLD_W        = 16,
  parameter int GAP_CYCLES    = 1000,
  parameter int SYNC_STAGES   = 2,
  parameter int BOUNCE_CYCLES = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_key_i,
  input  logic [HOLD_W-1:0] cmd_hold_i,
  input  logic [1:0]        col_in_i,
  output logic [1:0]        row_out_o,
  output logic              busy_o,
  output logic [3:0]        key_down_o
);

  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W = (HOLD_W > GAP_W) ? HOLD_W : GAP_W;

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic [3:0]          key_down_q;
  logic [1:0]          row_q;
  logic [1:0]          row_d;
  logic [1:0]          sync_q [SYNC_STAGES];
  logic [1:0]          col_s;
  logic [3:0]          contact;
  logic                accept;
  logic                cnt_last;
  logic [HOLD_W-1:0]   hold_eff;

  assign accept   = cmd_valid_i & cmd_ready_q;
  assign cnt_last = (cnt_q == CNT_W'(1));
  assign hold_eff = (cmd_hold_i == '0) ? HOLD_W'(1) : cmd_hold_i;
  assign col_s    = sync_q[SYNC_STAGES-1];

  // Counter is loaded with the full phase length and the phase ends on
  // the edge that sees 1, so an all-ones hold never wraps.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      key_down_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            state_q     <= PRESS;
            cnt_q       <= CNT_W'(hold_eff);
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            key_down_q  <= 4'b0001 << cmd_key_i;
          end
        end
        PRESS: begin
          if (cnt_last) begin
            state_q    <= GAP;
            cnt_q      <= CNT_W'(GAP_CYCLES);
            key_down_q <= '0;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_last) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      row_q <= '0;
    end else begin
      sync_q[0] <= col_in_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      row_q <= row_d;
    end
  end

`ifdef KEYEMU_BOUNCE_EN
  localparam int BC_W = $clog2(BOUNCE_CYCLES + 1);

  logic [7:0]      lfsr_q;
  logic [BC_W-1:0] bcnt_q;
  logic [1:0]      key_q;
  logic            win;
  logic            enter;

  // A window opens on entry to PRESS and again on entry to GAP.
  assign enter = accept | ((state_q == PRESS) & cnt_last);
  assign win   = (state_q != IDLE) &&
                 (bcnt_q < BC_W'(BOUNCE_CYCLES));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      lfsr_q <= 8'hA5;
      bcnt_q <= '0;
      key_q  <= '0;
    end else begin
      if (accept) begin
        key_q <= cmd_key_i;
      end
      if (win) begin
        lfsr_q <= {lfsr_q[6:0],
                   lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
      end
      if (enter) begin
        bcnt_q <= '0;
      end else if (win) begin
        bcnt_q <= bcnt_q + BC_W'(1);
      end
    end
  end
`endif

  always_comb begin
    contact = key_down_q;
`ifdef KEYEMU_BOUNCE_EN
    // GAP keeps key_q, so release bounce uses the key just released.
    if (win) begin
      contact        = '0;
      contact[key_q] = lfsr_q[0];
    end
`endif
    row_d[0] = (contact[0] & col_s[0]) | (contact[1] & col_s[1]);
    row_d[1] = (contact[2] & col_s[0]) | (contact[3] & col_s[1]);
  end

  assign cmd_ready_o = cmd_ready_q;
  assign busy_o      = busy_q;
  assign key_down_o  = key_down_q;
  assign row_out_o   = row_q;

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Directed testbench for keypad_matrix_emulator.
// Table-driven vectors plus hand sequences for multi-cycle corners.
module tb_keypad_matrix_emulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic        ready;
  logic [1:0]  key = '0;
  logic [15:0] hold = '0;
  logic [1:0]  col = 2'b01;
  logic [1:0]  row;
  logic        busy;
  logic [3:0]  kd;

  int n_vec = 0;
  int n_err = 0;

  keypad_matrix_emulator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (valid),
    .cmd_ready_o (ready),
    .cmd_key_i   (key),
    .cmd_hold_i  (hold),
    .col_in_i    (col),
    .row_out_o   (row),
    .busy_o      (busy),
    .key_down_o  (kd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic        rst;
    logic        vld;
    logic [1:0]  key;
    logic [15:0] hold;
    logic [1:0]  col;
    int          cyc;
    logic [7:0]  exp;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic add(input string nm, input logic r, input logic v,
                     input logic [1:0] k, input logic [15:0] h,
                     input logic [1:0] c, input int n,
                     input logic [7:0] e);
    vec_t t;
    t.nm = nm; t.rst = r; t.vld = v; t.key = k;
    t.hold = h; t.col = c; t.cyc = n; t.exp = e;
    tbl.push_back(t);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  d0, d1, d2;
    logic        was_rdy;
    int          idx;
    int          cyc;
    int          acc_t[3];
    logic [1:0]  keys[3];
    logic [15:0] holds[3];
    logic [7:0]  m;

`ifdef KEYEMU_BOUNCE_EN
    rst_n = 0; col = 2'b01;
    tick(); tick();
    rst_n = 1;
    tick();
    check("b_ready", ready, 1'b1);
    valid = 1; key = 2'd0; hold = 16'd100;
    tick();
    valid = 0;
    m = 8'hA5;
    for (int k = 0; k < 64; k++) begin
      tick();
      check("b_press", row, {1'b0, m[0]});
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
    for (int k = 0; k < 36; k++) begin
      tick();
      check("b_steady", row, 2'b01);
    end
    for (int k = 0; k < 64; k++) begin
      tick();
      check("b_gap", row, {1'b0, m[0]});
      m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3]};
    end
    tick();
    check("b_after", row, 2'b00);
`else
    // exp = {ready, busy, key_down[3:0], row[1:0]}
    add("rst",    0, 0, 0, 0,  2'b01, 2,   8'b0_0_0000_00);
    add("rdy",    1, 0, 0, 0,  2'b01, 1,   8'b1_0_0000_00);
    add("acc5",   1, 1, 0, 5,  2'b01, 1,   8'b0_1_0001_00);
    add("row1",   1, 0, 0, 5,  2'b01, 1,   8'b0_1_0001_01);
    add("pend",   1, 0, 0, 5,  2'b01, 3,   8'b0_1_0001_01);
    add("kdoff",  1, 0, 0, 5,  2'b01, 1,   8'b0_1_0000_01);
    add("rowoff", 1, 0, 0, 5,  2'b01, 1,   8'b0_1_0000_00);
    add("gapend", 1, 0, 0, 5,  2'b01, 998, 8'b0_1_0000_00);
    add("idle",   1, 0, 0, 5,  2'b01, 1,   8'b1_0_0000_00);
    add("acc10",  1, 1, 0, 10, 2'b01, 1,   8'b0_1_0001_00);
    add("p3",     1, 0, 0, 10, 2'b01, 2,   8'b0_1_0001_01);
    add("rstmid", 0, 0, 0, 10, 2'b01, 1,   8'b0_0_0000_00);
    add("relmid", 1, 0, 0, 10, 2'b01, 1,   8'b1_0_0000_00);
    add("nogap",  1, 0, 0, 10, 2'b11, 4,   8'b1_0_0000_00);
    add("acc2",   1, 1, 2, 4,  2'b11, 1,   8'b0_1_0100_00);
    add("c11row", 1, 0, 2, 4,  2'b00, 1,   8'b0_1_0100_10);
    add("c00d2",  1, 0, 2, 4,  2'b00, 1,   8'b0_1_0100_10);
    add("c00d3",  1, 0, 2, 4,  2'b00, 1,   8'b0_1_0100_00);
    add("h4end",  1, 0, 2, 4,  2'b00, 1,   8'b0_1_0000_00);
    add("rstgap", 0, 0, 0, 0,  2'b01, 1,   8'b0_0_0000_00);
    add("relgap", 1, 0, 0, 0,  2'b01, 1,   8'b1_0_0000_00);

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst;
      valid = tbl[i].vld;
      key   = tbl[i].key;
      hold  = tbl[i].hold;
      col   = tbl[i].col;
      repeat (tbl[i].cyc) tick();
      check(tbl[i].nm, {ready, busy, kd, row}, tbl[i].exp);
    end

    // Column toggling during a long press of key 3.
    valid = 1; key = 2'd3; hold = 16'd200;
    tick();
    valid = 0;
    d0 = 2'b01; d1 = 2'b01; d2 = 2'b01;
    for (int t = 0; t < 48; t++) begin
      if (t % 8 == 0) col = ((t / 8) % 2 == 1) ? 2'b01 : 2'b10;
      tick();
      d2 = d1; d1 = d0; d0 = col;
      check("toggle", {kd, row}, {4'b1000, d2[1], 1'b0});
    end
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();

    // Queued commands with cmd_valid held high.
    keys[0] = 2'd1; holds[0] = 16'd1;
    keys[1] = 2'd2; holds[1] = 16'd0;
    keys[2] = 2'd0; holds[2] = 16'd1;
    idx = 0; cyc = 0;
    valid = 1; key = keys[0]; hold = holds[0];
    while (idx < 3 && cyc < 4000) begin
      was_rdy = ready;
      tick();
      cyc++;
      if (was_rdy) begin
        acc_t[idx] = cyc;
        check("q_kd", kd, 4'b0001 << keys[idx]);
        idx++;
        if (idx < 3) begin
          key = keys[idx]; hold = holds[idx];
        end else begin
          valid = 0;
        end
      end
    end
    if (idx < 3) begin
      n_vec++; n_err++;
      $display("FAIL q_timeout: accepted %0d expected 3", idx);
    end else begin
      check("q_first", acc_t[0], 1);
      check("q_sp01", acc_t[1] - acc_t[0], 1002);
      check("q_sp12", acc_t[2] - acc_t[1], 1002);
      tick();
      check("q_h1", {busy, kd}, {1'b1, 4'b0000});
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
